// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_RX_FIFO_DEPTH = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write, registered read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Write-first bypass so the output register always equals the post-edge array content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata_q <= wdata;
    end else begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: strobe-driven push, FWFT valid/ready pop,
// registered fill flags and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, drop;

  // Read handshake: a byte leaves exactly when rd_valid && rd_ready at a rising edge;
  // rd_data is the head byte whenever rd_valid is high, and rd_ready alone does nothing.
  always_comb begin
    pop  = rd_valid_q && rd_ready;
    push = data_valid && ((count_q < CW'(DEPTH)) || pop);
    drop = data_valid && !push;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_valid_d = (count_d != '0);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    // A drop in the same cycle as a clear must leave the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  // Read address is the next-cycle head so the registered output tracks the pointer with no lag.
  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (CLK),
    .rst_n (RST),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (P_DATA),
    .raddr (rd_ptr_d),
    .rdata (rd_data)
  );

  assign rd_valid   = rd_valid_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
